remote_cmd_link: RTL and testbench
==================================

// Module: remote_cmd_link
// PURPOSE
//  Parametrised UART command transmitter / response receiver for the remote side of the link.
//  Serialises a CMD_BYTES-wide command MSB-byte first over TX and reports completion on cmd_snt.
//  Captures single-byte responses from RX and presents them on resp/resp_rdy.
//  Instantiates the team UART (tx+rx); sits between the test/host logic and the serial pins.
// PARAMETERS
//  CMD_BYTES   2       bytes per command, 1..8; cmd width = 8*CMD_BYTES
//  BAUD_DIV    2604    clk cycles per UART bit, forwarded to UART
//  TIMEOUT_CYC 1000000 response timeout in clk cycles (used only with RESP_TIMEOUT_EN)
// PORTS
//  clk       in   1             system clock
//  rst_n     in   1             asynchronous active-low reset
//  RX        in   1             serial in from remote
//  TX        out  1             serial out to remote
//  snd_cmd   in   1             1-cycle pulse: latch cmd, start transmission
//  cmd       in   8*CMD_BYTES   command word, sampled only when snd_cmd accepted
//  busy      out  1             high from accepted snd_cmd until last byte tx_done
//  cmd_snt   out  1             set on last byte tx_done, cleared by next accepted snd_cmd
//  resp      out  8             last received response byte
//  resp_rdy  out  1             response valid; cleared by next accepted snd_cmd
//  resp_tmo  out  1             response timeout flag (0 constant when RESP_TIMEOUT_EN undefined)
// BEHAVIOUR
//  Reset: TX=1 (idle), busy=0, cmd_snt=0, resp_rdy=0, resp=8'h00, resp_tmo=0, state=IDLE.
//  Datapath: shift register sh[8*CMD_BYTES-1:0]; tx_data = sh[top byte]; byte counter
//   cnt of width $clog2(CMD_BYTES+1) counts bytes remaining.
//  snd_cmd accepted only in IDLE; ignored (no latch, no effect) while busy.
//  On accept: sh<=cmd, cnt<=CMD_BYTES, clr_rx_rdy pulse, cmd_snt<=0, resp_tmo<=0, ->LOAD.
//  FSM IDLE/LOAD/XMIT:
//   LOAD: trmt=1 for exactly 1 cycle, cnt<=cnt-1, ->XMIT.
//   XMIT: on tx_done: if cnt==0 set cmd_snt, ->IDLE (RESP when timeout enabled);
//         else sh<=sh<<8, ->LOAD. Exactly one trmt per byte; never re-assert before tx_done.
//  Byte order: cmd[8*CMD_BYTES-1 -: 8] first, cmd[7:0] last. cmd changes after accept have no effect.
//  busy = (state!=IDLE && state!=RESP). cmd_snt and busy never both high.
//  Latency: trmt asserted 2 cycles after snd_cmd; cmd_snt high cycle after final tx_done.
//  CMD_BYTES=1: single LOAD/XMIT pass, no shift.
//  Responses: RX byte arriving at any time (incl. during XMIT) sets resp/resp_rdy via UART rx_rdy;
//   snd_cmd accept and a simultaneous rx_rdy: clear wins (resp_rdy=0 next cycle).
//  Reset asserted mid-command: immediate return to IDLE, TX forced idle-high, all flags cleared.
// CONFIGURATION
//  RESP_TIMEOUT_EN defined: extra state RESP after cmd_snt; 32-bit counter counts clk cycles;
//   resp_rdy -> IDLE, counter cleared; count reaches TIMEOUT_CYC-1 -> resp_tmo<=1, ->IDLE.
//   snd_cmd in RESP is accepted (abandons wait, resp_tmo stays 0). resp_tmo sticky until accept.
//  RESP_TIMEOUT_EN undefined: no RESP state, no counter, resp_tmo tied 0; FSM returns IDLE directly.
// TESTING
//  CMD_BYTES=2, cmd=16'hA55A pulse -> TX bytes A5 then 5A, 2 trmt pulses, cmd_snt=1, busy=0 after.
//  CMD_BYTES=4, cmd=32'hDEADBEEF -> bytes DE,AD,BE,EF in order; snd_cmd pulse mid-frame ignored.
//  Loopback TX->RX with remote model replying 8'hA5 -> resp=8'hA5, resp_rdy=1; next snd_cmd clears it.
//  rst_n low during 2nd byte -> TX=1, cmd_snt=0, busy=0 next edge; fresh cmd afterwards sent intact.
//  RESP_TIMEOUT_EN, TIMEOUT_CYC=500, no reply -> resp_tmo=1 exactly 500 cycles after cmd_snt rises.
//  CMD_BYTES=1, cmd=8'h3C -> single frame 3C, cmd_snt set after one tx_done.

Source files
------------

// File: rtl/remote_cmd_link.sv
// +----------------------------------------------------------------------------+
// | remote_cmd_link : UART command transmitter / response receiver (remote end) |
// | Sends CMD_BYTES-wide commands MSB byte first; captures 1-byte responses.    |
// | Optional feature macro: RESP_TIMEOUT_EN (response wait state + timeout)    |
// | Rev 1.0  initial release                                                   |
// +----------------------------------------------------------------------------+
`default_nettype none

module uart_tx #(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       TX,
  output logic       tx_done
);
  localparam int BW = $clog2(BAUD_DIV + 1);

  logic [9:0]    shreg;
  logic [BW-1:0] baud;
  logic [3:0]    bits;
  logic          active;

  // Frame is {stop, data[7:0], start}; ones shift in so the line rests high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg   <= '1;
      baud    <= '0;
      bits    <= '0;
      active  <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (!active) begin
        if (trmt) begin
          shreg  <= {1'b1, tx_data, 1'b0};
          baud   <= '0;
          bits   <= '0;
          active <= 1'b1;
        end
      end else if (baud == BW'(BAUD_DIV - 1)) begin
        baud <= '0;
        if (bits == 4'd9) begin
          active  <= 1'b0;
          tx_done <= 1'b1;
        end else begin
          shreg <= {1'b1, shreg[9:1]};
          bits  <= bits + 4'd1;
        end
      end else begin
        baud <= baud + BW'(1);
      end
    end
  end

  assign TX = shreg[0];
endmodule

module uart_rx #(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  output logic       rx_rdy,
  output logic [7:0] rx_data
);
  localparam int BW = $clog2(BAUD_DIV + 1);

  logic          rx_ff1;
  logic          rx_s;
  logic [BW-1:0] baud;
  logic [3:0]    bits;
  logic [7:0]    sh;
  logic          active;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_ff1  <= 1'b1;
      rx_s    <= 1'b1;
      baud    <= '0;
      bits    <= '0;
      sh      <= '0;
      active  <= 1'b0;
      rx_rdy  <= 1'b0;
      rx_data <= '0;
    end else begin
      rx_ff1 <= RX;
      rx_s   <= rx_ff1;
      rx_rdy <= 1'b0;
      if (!active) begin
        if (!rx_s) begin
          active <= 1'b1;
          baud   <= BW'(BAUD_DIV / 2);
          bits   <= '0;
        end
      end else if (baud == '0) begin
        // Sampling near the centre of each bit cell.
        baud <= BW'(BAUD_DIV - 1);
        if (bits == 4'd9) begin
          active  <= 1'b0;
          rx_rdy  <= 1'b1;
          rx_data <= sh;
        end else if (bits == 4'd0 && rx_s) begin
          active <= 1'b0;
        end else begin
          if (bits != 4'd0) sh <= {rx_s, sh[7:1]};
          bits <= bits + 4'd1;
        end
      end else begin
        baud <= baud - BW'(1);
      end
    end
  end
endmodule

module remote_cmd_link #(
  parameter int CMD_BYTES   = 2,
  parameter int BAUD_DIV    = 2604,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   RX,
  output logic                   TX,
  input  logic                   snd_cmd,
  input  logic [8*CMD_BYTES-1:0] cmd,
  output logic                   busy,
  output logic                   cmd_snt,
  output logic [7:0]             resp,
  output logic                   resp_rdy,
  output logic                   resp_tmo
);
  localparam int W     = 8 * CMD_BYTES;
  localparam int CNT_W = $clog2(CMD_BYTES + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    XMIT = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t           state;
  logic [W-1:0]     sh;
  logic [CNT_W-1:0] cnt;
  logic             trmt;
  logic             tx_done;
  logic             rx_rdy;
  logic [7:0]       rx_data;
  logic [7:0]       tx_data;
  logic             accept;
  logic             clr_rx_rdy;

  assign tx_data    = sh[W-1 -: 8];
  assign accept     = snd_cmd && (state == IDLE || state == RESP);
  assign clr_rx_rdy = accept;
  assign busy       = (state == LOAD) || (state == XMIT);

  uart_tx #(.BAUD_DIV(BAUD_DIV)) u_tx (
    .clk     (clk),
    .rst_n   (rst_n),
    .trmt    (trmt),
    .tx_data (tx_data),
    .TX      (TX),
    .tx_done (tx_done)
  );

  uart_rx #(.BAUD_DIV(BAUD_DIV)) u_rx (
    .clk     (clk),
    .rst_n   (rst_n),
    .RX      (RX),
    .rx_rdy  (rx_rdy),
    .rx_data (rx_data)
  );

`ifdef RESP_TIMEOUT_EN
  logic [31:0] tmo_cnt;
`else
  assign resp_tmo = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      sh      <= '0;
      cnt     <= '0;
      trmt    <= 1'b0;
      cmd_snt <= 1'b0;
`ifdef RESP_TIMEOUT_EN
      tmo_cnt  <= '0;
      resp_tmo <= 1'b0;
`endif
    end else begin
      trmt <= 1'b0;
      if (accept) begin
        sh      <= cmd;
        cnt     <= CNT_W'(CMD_BYTES);
        cmd_snt <= 1'b0;
        state   <= LOAD;
`ifdef RESP_TIMEOUT_EN
        tmo_cnt  <= '0;
        resp_tmo <= 1'b0;
`endif
      end else begin
        case (state)
          LOAD: begin
            trmt  <= 1'b1;
            cnt   <= cnt - CNT_W'(1);
            state <= XMIT;
          end
          XMIT: begin
            if (tx_done) begin
              if (cnt == '0) begin
                cmd_snt <= 1'b1;
`ifdef RESP_TIMEOUT_EN
                tmo_cnt <= '0;
                state   <= RESP;
`else
                state   <= IDLE;
`endif
              end else begin
                sh    <= sh << 8;
                state <= LOAD;
              end
            end
          end
`ifdef RESP_TIMEOUT_EN
          RESP: begin
            if (resp_rdy) begin
              tmo_cnt <= '0;
              state   <= IDLE;
            end else if (tmo_cnt == 32'(TIMEOUT_CYC - 1)) begin
              resp_tmo <= 1'b1;
              tmo_cnt  <= '0;
              state    <= IDLE;
            end else begin
              tmo_cnt <= tmo_cnt + 32'd1;
            end
          end
`endif
          default: state <= IDLE;
        endcase
      end
    end
  end

  // A new command clears the previous response even if a byte lands that cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp     <= 8'h00;
      resp_rdy <= 1'b0;
    end else begin
      if (rx_rdy) resp <= rx_data;
      if (clr_rx_rdy)  resp_rdy <= 1'b0;
      else if (rx_rdy) resp_rdy <= 1'b1;
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_remote_cmd_link.sv
// +----------------------------------------------------------------------------+
// | tb_remote_cmd_link : directed self-checking bench for remote_cmd_link       |
// | Rev 1.0  initial release                                                   |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_remote_cmd_link;
  localparam int BD  = 8;
  localparam int TMO = 500;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        snd2 = 1'b0, snd4 = 1'b0, snd1 = 1'b0;
  logic [15:0] cmd2 = '0;
  logic [31:0] cmd4 = '0;
  logic [7:0]  cmd1 = '0;
  logic        rx2 = 1'b1;
  logic        rx4 = 1'b1, rx1 = 1'b1;
  logic        tx2, tx4, tx1;
  logic        busy2, busy4, busy1;
  logic        snt2, snt4, snt1;
  logic [7:0]  resp2, resp4, resp1;
  logic        rdy2, rdy4, rdy1;
  logic        tmo2, tmo4, tmo1;

  int checks = 0;
  int failures = 0;
  int sel = 0;
  logic mon_tx;

  always_comb begin
    mon_tx = tx1;
    if (sel == 0) mon_tx = tx2;
    else if (sel == 1) mon_tx = tx4;
  end

  remote_cmd_link #(.CMD_BYTES(2), .BAUD_DIV(BD), .TIMEOUT_CYC(TMO)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .RX(rx2), .TX(tx2), .snd_cmd(snd2), .cmd(cmd2),
    .busy(busy2), .cmd_snt(snt2), .resp(resp2), .resp_rdy(rdy2), .resp_tmo(tmo2));

  remote_cmd_link #(.CMD_BYTES(4), .BAUD_DIV(BD), .TIMEOUT_CYC(TMO)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .RX(rx4), .TX(tx4), .snd_cmd(snd4), .cmd(cmd4),
    .busy(busy4), .cmd_snt(snt4), .resp(resp4), .resp_rdy(rdy4), .resp_tmo(tmo4));

  remote_cmd_link #(.CMD_BYTES(1), .BAUD_DIV(BD), .TIMEOUT_CYC(TMO)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .RX(rx1), .TX(tx1), .snd_cmd(snd1), .cmd(cmd1),
    .busy(busy1), .cmd_snt(snt1), .resp(resp1), .resp_rdy(rdy1), .resp_tmo(tmo1));

  // Serial capture of one frame from the selected TX line, sampled mid-bit.
  task automatic capture_byte(output logic [7:0] b, output logic ok);
    logic found;
    found = 1'b0;
    ok = 1'b0;
    b = 8'h00;
    for (int i = 0; i < 40 * BD; i++) begin
      @(negedge clk);
      if (mon_tx === 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    if (found) begin
      repeat (BD / 2) @(negedge clk);
      if (mon_tx === 1'b0) begin
        for (int j = 0; j < 8; j++) begin
          repeat (BD) @(negedge clk);
          b[j] = mon_tx;
        end
        repeat (BD) @(negedge clk);
        ok = (mon_tx === 1'b1);
      end
    end
  endtask

  task automatic send_rx2(input logic [7:0] b);
    logic [9:0] frame;
    frame = {1'b1, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      rx2 = frame[k];
      repeat (BD - 1) @(negedge clk);
    end
  endtask

  task automatic wait_snt(input int which);
    for (int i = 0; i < 4 * BD; i++) begin
      @(negedge clk);
      if ((which == 0 && snt2) || (which == 1 && snt4) || (which == 2 && snt1)) break;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({tx2, busy2, snt2, rdy2, resp2, tmo2} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0}) begin
      failures++;
      $display("FAIL reset_dut2 got=%b want=%b", {tx2, busy2, snt2, rdy2, resp2, tmo2}, 13'b1_0_0_0_00000000_0);
    end
    checks++;
    if ({tx4, busy4, snt4, rdy4, tx1, busy1, snt1, rdy1} !== 8'b1000_1000) begin
      failures++;
      $display("FAIL reset_dut4_dut1 got=%b want=10001000", {tx4, busy4, snt4, rdy4, tx1, busy1, snt1, rdy1});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_cmd2;
    logic [7:0] b;
    logic ok;
    sel = 0;
    cmd2 = 16'hA55A;
    snd2 = 1'b1;
    @(negedge clk);
    snd2 = 1'b0;
    cmd2 = 16'h0000;
    checks++;
    if ({busy2, snt2} !== 2'b10) begin
      failures++;
      $display("FAIL cmd2_busy_after_accept got=%b want=10", {busy2, snt2});
    end
    @(negedge clk);
    checks++;
    if (tx2 !== 1'b1) begin
      failures++;
      $display("FAIL cmd2_tx_idle_during_load got=%b want=1", tx2);
    end
    @(negedge clk);
    checks++;
    if (tx2 !== 1'b0) begin
      failures++;
      $display("FAIL cmd2_start_bit_latency got=%b want=0", tx2);
    end
    capture_byte(b, ok);
    checks++;
    if (!ok || b !== 8'hA5) begin
      failures++;
      $display("FAIL cmd2_byte0 got=%h ok=%b want=a5", b, ok);
    end
    capture_byte(b, ok);
    checks++;
    if (!ok || b !== 8'h5A) begin
      failures++;
      $display("FAIL cmd2_byte1 got=%h ok=%b want=5a", b, ok);
    end
    wait_snt(0);
    checks++;
    if ({snt2, busy2} !== 2'b10) begin
      failures++;
      $display("FAIL cmd2_done got snt,busy=%b want=10", {snt2, busy2});
    end
  endtask

  task automatic test_loopback;
    logic [7:0] b;
    logic ok;
    sel = 0;
    send_rx2(8'hA5);
    for (int i = 0; i < 4 * BD && !rdy2; i++) @(negedge clk);
    checks++;
    if ({rdy2, resp2} !== {1'b1, 8'hA5}) begin
      failures++;
      $display("FAIL loop_resp got rdy=%b resp=%h want rdy=1 resp=a5", rdy2, resp2);
    end
    cmd2 = 16'h0102;
    snd2 = 1'b1;
    @(negedge clk);
    snd2 = 1'b0;
    checks++;
    if ({rdy2, snt2, resp2} !== {1'b0, 1'b0, 8'hA5}) begin
      failures++;
      $display("FAIL loop_clear got rdy=%b snt=%b resp=%h want 0 0 a5", rdy2, snt2, resp2);
    end
    capture_byte(b, ok);
    capture_byte(b, ok);
    checks++;
    if (!ok || b !== 8'h02) begin
      failures++;
      $display("FAIL loop_cmd_last_byte got=%h ok=%b want=02", b, ok);
    end
    wait_snt(0);
  endtask

  task automatic test_back_to_back;
    logic [7:0] b;
    logic ok;
    logic activity;
    sel = 1;
    cmd4 = 32'hDEADBEEF;
    snd4 = 1'b1;
    @(negedge clk);
    snd4 = 1'b0;
    capture_byte(b, ok);
    checks++;
    if (!ok || b !== 8'hDE) begin
      failures++;
      $display("FAIL cmd4_byte0 got=%h ok=%b want=de", b, ok);
    end
    cmd4 = 32'h12345678;
    snd4 = 1'b1;
    @(negedge clk);
    snd4 = 1'b0;
    checks++;
    if (busy4 !== 1'b1) begin
      failures++;
      $display("FAIL cmd4_busy_mid_frame got=%b want=1", busy4);
    end
    capture_byte(b, ok);
    checks++;
    if (!ok || b !== 8'hAD) begin
      failures++;
      $display("FAIL cmd4_byte1 got=%h ok=%b want=ad", b, ok);
    end
    capture_byte(b, ok);
    checks++;
    if (!ok || b !== 8'hBE) begin
      failures++;
      $display("FAIL cmd4_byte2 got=%h ok=%b want=be", b, ok);
    end
    capture_byte(b, ok);
    checks++;
    if (!ok || b !== 8'hEF) begin
      failures++;
      $display("FAIL cmd4_byte3 got=%h ok=%b want=ef", b, ok);
    end
    wait_snt(1);
    checks++;
    if ({snt4, busy4} !== 2'b10) begin
      failures++;
      $display("FAIL cmd4_done got snt,busy=%b want=10", {snt4, busy4});
    end
    activity = 1'b0;
    repeat (3 * BD) begin
      @(negedge clk);
      if (busy4 !== 1'b0 || tx4 !== 1'b1) activity = 1'b1;
    end
    checks++;
    if (activity !== 1'b0) begin
      failures++;
      $display("FAIL cmd4_ignored_pulse_sent got=%b want=0", activity);
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] b;
    logic ok;
    sel = 0;
    cmd2 = 16'hC33C;
    snd2 = 1'b1;
    @(negedge clk);
    snd2 = 1'b0;
    capture_byte(b, ok);
    for (int i = 0; i < 10 * BD && tx2 !== 1'b0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({tx2, snt2, busy2} !== 3'b100) begin
      failures++;
      $display("FAIL reset_mid got tx,snt,busy=%b want=100", {tx2, snt2, busy2});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    cmd2 = 16'h9617;
    snd2 = 1'b1;
    @(negedge clk);
    snd2 = 1'b0;
    capture_byte(b, ok);
    checks++;
    if (!ok || b !== 8'h96) begin
      failures++;
      $display("FAIL reset_fresh_byte0 got=%h ok=%b want=96", b, ok);
    end
    capture_byte(b, ok);
    checks++;
    if (!ok || b !== 8'h17) begin
      failures++;
      $display("FAIL reset_fresh_byte1 got=%h ok=%b want=17", b, ok);
    end
    wait_snt(0);
    checks++;
    if ({snt2, busy2} !== 2'b10) begin
      failures++;
      $display("FAIL reset_fresh_done got snt,busy=%b want=10", {snt2, busy2});
    end
  endtask

  task automatic test_single_and_timeout;
    logic [7:0] b;
    logic ok;
    int n;
    sel = 2;
    cmd1 = 8'h3C;
    snd1 = 1'b1;
    @(negedge clk);
    snd1 = 1'b0;
    capture_byte(b, ok);
    checks++;
    if (!ok || b !== 8'h3C) begin
      failures++;
      $display("FAIL single_byte got=%h ok=%b want=3c", b, ok);
    end
    wait_snt(2);
    checks++;
    if ({snt1, busy1, tmo1} !== 3'b100) begin
      failures++;
      $display("FAIL single_done got snt,busy,tmo=%b want=100", {snt1, busy1, tmo1});
    end
    n = 0;
`ifdef RESP_TIMEOUT_EN
    for (int i = 0; i < 4 * TMO; i++) begin
      @(negedge clk);
      n++;
      if (tmo1 === 1'b1) break;
    end
    checks++;
    if (n !== TMO || tmo1 !== 1'b1) begin
      failures++;
      $display("FAIL timeout_latency got cycles=%0d tmo=%b want cycles=%0d tmo=1", n, tmo1, TMO);
    end
`else
    for (int i = 0; i < TMO + 100; i++) begin
      @(negedge clk);
      if (tmo1 !== 1'b0) n++;
    end
    checks++;
    if (n !== 0) begin
      failures++;
      $display("FAIL tmo_tied_low got high_cycles=%0d want=0", n);
    end
`endif
    cmd1 = 8'hC3;
    snd1 = 1'b1;
    @(negedge clk);
    snd1 = 1'b0;
    checks++;
    if ({tmo1, snt1, busy1} !== 3'b001) begin
      failures++;
      $display("FAIL single_reaccept got tmo,snt,busy=%b want=001", {tmo1, snt1, busy1});
    end
    capture_byte(b, ok);
    checks++;
    if (!ok || b !== 8'hC3) begin
      failures++;
      $display("FAIL single_second got=%h ok=%b want=c3", b, ok);
    end
    wait_snt(2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_cmd2();
    test_loopback();
    test_back_to_back();
    test_reset_mid();
    test_single_and_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

`default_nettype wire
